hbm_rd_dispatch_mc: RTL
=======================

Name: hbm_rd_dispatch_mc

Overview:
Multi-channel successor to the single A/B HBM read-response dispatcher. It accepts AXI3 read-data beats from one HBM pseudo-channel and routes each beat to one of NUM_CH compute-side FIFOs, selected by the low bits of RID. Each channel has its own backpressure and a runtime enable mask. The block tracks job progress against a programmed byte length and exports stall, drop, error and beat counters for debug.

Parameters:
DATA_WIDTH, 256, R-channel data width in bits; power of 2, at least 64.
ID_WIDTH, 6, RID width.
NUM_CH, 4, number of output channels; power of 2, 2..16; CH_W = clog2(NUM_CH), and CH_W ≤ ID_WIDTH.
PIPE_DEPTH, 3, register stages from beat acceptance to ch_wr_en; 1..8.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle job start pulse
data_length  in  32  job size in bytes; sampled on start
ch_enable  in  NUM_CH  per-channel enable mask
m_axi_RVALID  in  1  read data valid
m_axi_RDATA  in  DATA_WIDTH  read data
m_axi_RLAST  in  1  last beat of burst
m_axi_RID  in  ID_WIDTH  read ID; bits [CH_W-1:0] select the channel
m_axi_RRESP  in  2  read response
m_axi_RREADY  out  1  read ready (registered)
ch_almost_full  in  NUM_CH  per-channel FIFO almost-full
ch_data  out  DATA_WIDTH  shared data bus to all channels
ch_last  out  1  RLAST of the beat on ch_data
ch_wr_en  out  NUM_CH  one-hot write strobe
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
beat_cnt  out  32  beats counted toward the current job
stall_cnt  out  32  cycles in RUN with RVALID=1 and RREADY=0
drop_cnt  out  32  accepted beats addressed to a disabled channel
err_cnt  out  32  accepted beats with RRESP != 0
run_cycles  out  32  cycles spent in RUN for the last or current job

Behaviour:
- Reset: every output is 0, state is IDLE, the pipeline is flushed, and RREADY is 0.
- RREADY is a register: each cycle it loads ~|(ch_almost_full & ch_enable). Disabled channels never throttle. Downstream almost_full thresholds must absorb PIPE_DEPTH+2 in-flight beats.
- Accept condition: acc = RVALID & RREADY. For an accepted beat, ch = RID[CH_W-1:0].
- Dispatch: if ch_enable[ch], then exactly PIPE_DEPTH cycles after acceptance, ch_wr_en[ch]=1 with ch_data=RDATA and ch_last=RLAST. Otherwise no strobe is issued and drop_cnt increments.
  - ch_wr_en bits are 0 in every other cycle. Data and last stages are not reset; only the valid stages are.
  - ch_enable is sampled at the acceptance cycle.
- err_cnt increments on every accepted beat with RRESP != 0, whether it is dispatched or dropped. The data is still forwarded.
- FSM states are IDLE, RUN, DONE.
  - start (any state) latches exp_beats = data_length >> log2(DATA_WIDTH/8). It clears beat_cnt, stall_cnt, drop_cnt, err_cnt and run_cycles, then enters RUN. start has priority over all other events in the same cycle; a beat accepted in the start cycle is not counted.
  - RUN: beat_cnt increments on each acc (dropped beats included). run_cycles increments every cycle.
  - RUN → DONE on the cycle in which beat_cnt+acc reaches exp_beats. done pulses for 1 cycle on DONE entry.
  - exp_beats=0: RUN lasts 1 cycle, then DONE.
  - DONE → IDLE on the next cycle.
  - busy=1 only in RUN.
- Outside RUN, beats are still accepted and dispatched but do not change beat_cnt or run_cycles; drop_cnt and err_cnt still count.
- Counters are 32 bits and wrap modulo 2^32. Sub-beat remainders of data_length are ignored (truncation).
- Reset mid-job abandons all in-flight beats; no ch_wr_en is issued after reset.

Test Plan:
1. NUM_CH=4, all enabled, no backpressure, data_length=512 (16 beats), RID cycling 0..3 → 4 strobes per channel; each strobe arrives 3 cycles after acceptance with matching data; done pulses once; beat_cnt=16.
2. Assert ch_almost_full[2] for 10 cycles with RVALID=1 → RREADY drops 1 cycle later; stall_cnt=10; no beat is lost or duplicated.
3. ch_enable=4'b1011, then ch_almost_full[2]=1 and RID=2 beats → RREADY stays 1; drop_cnt counts the RID=2 beats; ch_wr_en[2] never asserts.
4. RRESP=2'b10 on 3 of 8 beats → err_cnt=3; all 8 beats are dispatched.
5. start with data_length=0 → busy for 1 cycle, then done. start again mid-job with 64 bytes → counters clear; done arrives after 2 further beats.
6. rst_n low while 3 beats are in the pipeline → all outputs are 0 next cycle; no ch_wr_en follows.

Source files
------------

// File: rtl/hbm_rd_dispatch_mc.sv
// hbm_rd_dispatch_mc: routes AXI3 read-data beats from one HBM pseudo-channel
// to NUM_CH compute-side FIFOs selected by RID low bits. Tracks job progress
// against a programmed byte length and exposes debug counters.
module hbm_rd_dispatch_mc #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int NUM_CH     = 4,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           data_length,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic                  m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic                  m_axi_RLAST,
  input  logic [ID_WIDTH-1:0]   m_axi_RID,
  input  logic [1:0]            m_axi_RRESP,
  output logic                  m_axi_RREADY,
  input  logic [NUM_CH-1:0]     ch_almost_full,
  output logic [DATA_WIDTH-1:0] ch_data,
  output logic                  ch_last,
  output logic [NUM_CH-1:0]     ch_wr_en,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           drop_cnt,
  output logic [31:0]           err_cnt,
  output logic [31:0]           run_cycles
);

  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  rready_q;
  logic                  acc;
  logic [CH_W-1:0]       acc_ch;
  logic                  acc_ch_en;
  logic [NUM_CH-1:0]     sel_oh;
  logic [31:0]           exp_beats;
  logic [31:0]           beat_nxt;
  logic                  unused_rid;

  logic [NUM_CH-1:0]     vld_p  [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] data_p [PIPE_DEPTH];
  logic                  last_p [PIPE_DEPTH];

  // Only the channel-select bits of RID matter; upper bits are tag info.
  assign unused_rid = ^m_axi_RID;

  assign acc       = m_axi_RVALID & rready_q;
  assign acc_ch    = m_axi_RID[CH_W-1:0];
  assign acc_ch_en = ch_enable[acc_ch];
  assign sel_oh    = (acc && acc_ch_en)
                     ? ({{(NUM_CH-1){1'b0}}, 1'b1} << acc_ch)
                     : '0;
  assign beat_nxt  = beat_cnt + {31'd0, acc};

  assign m_axi_RREADY = rready_q;

  // Ready is registered; only enabled channels may throttle the R channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rready_q <= 1'b0;
    end else begin
      rready_q <= ~|(ch_almost_full & ch_enable);
    end
  end

  // Stage p0 captures the accepted beat; valid shifts as a one-hot strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        vld_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= sel_oh;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Data/last ride alongside valid without reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    data_p[0] <= m_axi_RDATA;
    last_p[0] <= m_axi_RLAST;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      data_p[i] <= data_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  // Final stage boundary: drive the shared bus, zeroed when no strobe so
  // that nothing stale is visible (and the bus is 0 straight out of reset).
  assign ch_wr_en = vld_p[PIPE_DEPTH-1];
  assign ch_data  = (|vld_p[PIPE_DEPTH-1]) ? data_p[PIPE_DEPTH-1] : '0;
  assign ch_last  = (|vld_p[PIPE_DEPTH-1]) & last_p[PIPE_DEPTH-1];

  // Job FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; start overrides everything else.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: ;
      RUN: begin
        busy = 1'b1;
        if (exp_beats == 32'd0 || beat_nxt == exp_beats) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt = RUN;
    end
  end

  // Job length and debug counters; a beat in the start cycle is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_beats  <= '0;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
      run_cycles <= '0;
    end else if (start) begin
      exp_beats  <= data_length >> BEAT_SHIFT;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
      run_cycles <= '0;
    end else begin
      if (state == RUN) begin
        beat_cnt   <= beat_nxt;
        run_cycles <= run_cycles + 32'd1;
        if (m_axi_RVALID && !rready_q) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
      end
      if (acc && !acc_ch_en) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
      if (acc && (m_axi_RRESP != 2'b00)) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end

endmodule
